// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding bus fetch at a time, a one-entry
// hold buffer toward decode, and redirect handling that drops stale responses.
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

// state  | meaning
// S_IDLE | first cycle after reset, no request
// S_REQ  | presenting request at pc (or detecting misaligned pc)
// S_WAIT | address accepted, waiting for data_ok
// S_HOLD | instruction (or fetch fault) presented to decode
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        discard, discard_nxt;
  logic [31:0] held_instr, held_instr_nxt;
  logic        held_exc, held_exc_nxt;

  logic        misaligned;
  logic        addr_hs;

  assign misaligned = |pc[1:0];
  // A misaligned pc never raises valid, so addr_ok cannot complete a handshake then.
  assign addr_hs    = (state == S_REQ) && !misaligned && iresp.addr_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      discard    <= 1'b0;
      held_instr <= '0;
      held_exc   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      discard    <= discard_nxt;
      held_instr <= held_instr_nxt;
      held_exc   <= held_exc_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    discard_nxt    = discard;
    held_instr_nxt = held_instr;
    held_exc_nxt   = held_exc;
    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        if (redirect_valid) pc_nxt = redirect_pc;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
          if (addr_hs) begin
            discard_nxt = 1'b1;
            state_nxt   = S_WAIT;
          end
        end else if (misaligned) begin
          held_instr_nxt = '0;
          held_exc_nxt   = 1'b1;
          state_nxt      = S_HOLD;
        end else if (addr_hs) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // The response in flight belongs to the old pc; mark it for dropping.
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
          if (iresp.data_ok) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            discard_nxt = 1'b1;
          end
        end else if (iresp.data_ok) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            held_instr_nxt = iresp.data;
            held_exc_nxt   = 1'b0;
            state_nxt      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_REQ;
        end else if (out_ready) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ireq.valid = (state == S_REQ) && !misaligned;
    ireq.addr  = pc;
    ireq.size  = MSIZE4;
    out_valid  = (state == S_HOLD);
    out_pc     = pc;
    out_instr  = out_valid ? held_instr : '0;
    out_exc    = out_valid && held_exc;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table for the main fetch flow plus
// short hand-written sequences for redirect and reset corner cases.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_PC(32'hbfc0_0000)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_exc        (out_exc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [31:0] ia;
    logic [1:0]  isz;
    logic        ov;
    logic [31:0] opc;
    logic [31:0] oi;
    logic        oe;
  } out_t;

  typedef struct packed {
    logic        rstn;
    logic        redir;
    logic [31:0] rpc;
    logic        aok;
    logic        dok;
    logic [31:0] data;
    logic        ordy;
    out_t        e;
  } vec_t;

  vec_t tbl[$];

  function automatic out_t e_bus(logic iv, logic [31:0] addr);
    out_t r;
    r = '{iv: iv, ia: addr, isz: 2'd2, ov: 1'b0, opc: addr, oi: 32'h0, oe: 1'b0};
    return r;
  endfunction

  function automatic out_t e_hold(logic [31:0] pc, logic [31:0] instr, logic exc);
    out_t r;
    r = '{iv: 1'b0, ia: pc, isz: 2'd2, ov: 1'b1, opc: pc, oi: instr, oe: exc};
    return r;
  endfunction

  function automatic vec_t mk(logic rstn, logic redir, logic [31:0] rpc, logic aok,
                              logic dok, logic [31:0] data, logic ordy, out_t e);
    vec_t v;
    v = '{rstn: rstn, redir: redir, rpc: rpc, aok: aok, dok: dok, data: data, ordy: ordy, e: e};
    return v;
  endfunction

  // Inputs go on at the falling edge; outputs are checked before the next rising edge.
  task automatic apply(string name, vec_t v);
    out_t got;
    @(negedge clk);
    resetn         = v.rstn;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    out_ready      = v.ordy;
    iresp.addr_ok  = v.aok;
    iresp.data_ok  = v.dok;
    iresp.data     = v.data;
    #1;
    got = '{iv: ireq.valid, ia: ireq.addr, isz: ireq.size, ov: out_valid,
            opc: out_pc, oi: out_instr, oe: out_exc};
    checks++;
    if (got !== v.e) begin
      errors++;
      $display("FAIL %s: got ireq.valid=%b addr=%h size=%0d out_valid=%b pc=%h instr=%h exc=%b; required ireq.valid=%b addr=%h size=%0d out_valid=%b pc=%h instr=%h exc=%b",
               name, got.iv, got.ia, got.isz, got.ov, got.opc, got.oi, got.oe,
               v.e.iv, v.e.ia, v.e.isz, v.e.ov, v.e.opc, v.e.oi, v.e.oe);
    end
  endtask

  task automatic step(string name, logic redir, logic [31:0] rpc, logic aok, logic dok,
                      logic [31:0] data, logic ordy, out_t e);
    apply(name, mk(1'b1, redir, rpc, aok, dok, data, ordy, e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    iresp = '0;
    repeat (2) @(posedge clk);

    // reset, first fetch with immediate addr_ok and data two cycles later
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, e_bus(0, 32'hbfc0_0000)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, e_bus(0, 32'hbfc0_0000)));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, e_bus(1, 32'hbfc0_0000)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, e_bus(0, 32'hbfc0_0000)));
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h2402_0001, 0, e_bus(0, 32'hbfc0_0000)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, e_hold(32'hbfc0_0000, 32'h2402_0001, 0)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, e_hold(32'hbfc0_0000, 32'h2402_0001, 0)));
    // addr_ok stalled 5 cycles, then decode stalls 3 cycles
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, e_bus(1, 32'hbfc0_0004)));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, e_bus(1, 32'hbfc0_0004)));
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0000_0013, 0, e_bus(0, 32'hbfc0_0004)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, e_hold(32'hbfc0_0004, 32'h0000_0013, 0)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, e_hold(32'hbfc0_0004, 32'h0000_0013, 0)));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, e_bus(1, 32'hbfc0_0008)));
    // redirect in S_WAIT, stale dead_beef dropped
    tbl.push_back(mk(1, 1, 32'h8000_0100, 0, 0, 0, 0, e_bus(0, 32'hbfc0_0008)));
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'hdead_beef, 0, e_bus(0, 32'h8000_0100)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, e_bus(1, 32'h8000_0100)));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, e_bus(1, 32'h8000_0100)));
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h8c00_0004, 0, e_bus(0, 32'h8000_0100)));
    // redirect in S_HOLD to misaligned target -> fault entry, no bus request
    tbl.push_back(mk(1, 1, 32'h8000_0102, 0, 0, 0, 0, e_hold(32'h8000_0100, 32'h8c00_0004, 0)));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, e_bus(0, 32'h8000_0102)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, e_hold(32'h8000_0102, 32'h0, 1)));
    // redirect beats out_ready; then pc wraps past 0xffff_fffc
    tbl.push_back(mk(1, 1, 32'hffff_fffc, 0, 0, 0, 1, e_hold(32'h8000_0102, 32'h0, 1)));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, e_bus(1, 32'hffff_fffc)));
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h1111_2222, 0, e_bus(0, 32'hffff_fffc)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, e_hold(32'hffff_fffc, 32'h1111_2222, 0)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, e_bus(1, 32'h0000_0000)));

    for (int i = 0; i < tbl.size(); i++)
      apply($sformatf("vec%0d", i), tbl[i]);

    // redirect in S_REQ without handshake: address moves, stays in S_REQ
    step("req_redir",      1, 32'h0000_0040, 0, 0, 0, 0, e_bus(1, 32'h0000_0000));
    step("req_redir_addr", 0, 0,             0, 0, 0, 0, e_bus(1, 32'h0000_0040));
    step("req_redir_hs",   0, 0,             1, 0, 0, 0, e_bus(1, 32'h0000_0040));

    // two redirects in S_WAIT: newest pc wins, exactly one response dropped
    step("wait_redir1",    1, 32'h0000_0100, 0, 0, 0, 0, e_bus(0, 32'h0000_0040));
    step("wait_redir2",    1, 32'h0000_0200, 1, 0, 0, 0, e_bus(0, 32'h0000_0100));
    step("wait_drop",      0, 0, 0, 1, 32'haaaa_aaaa, 0, e_bus(0, 32'h0000_0200));
    step("wait_refetch",   0, 0, 0, 0, 0, 0,             e_bus(1, 32'h0000_0200));
    step("wait_refetch_hs",0, 0, 1, 0, 0, 0,             e_bus(1, 32'h0000_0200));
    step("wait_keep",      0, 0, 0, 1, 32'h1234_5678, 0, e_bus(0, 32'h0000_0200));
    step("wait_kept",      0, 0, 0, 0, 0, 0,             e_hold(32'h0000_0200, 32'h1234_5678, 0));

    // redirect with out_ready in S_HOLD: entry consumed, no pc+4
    step("hold_redir",     1, 32'h0000_0300, 0, 0, 0, 1, e_hold(32'h0000_0200, 32'h1234_5678, 0));
    step("hold_redir_pc",  0, 0, 1, 0, 0, 0,             e_bus(1, 32'h0000_0300));

    // redirect and data_ok together in S_WAIT
    step("wait_redir_dok", 1, 32'h0000_0400, 0, 1, 32'hbbbb_bbbb, 0, e_bus(0, 32'h0000_0300));
    step("wait_redir_req", 0, 0, 0, 0, 0, 0,             e_bus(1, 32'h0000_0400));
    step("wait_redir_hs",  0, 0, 1, 0, 0, 0,             e_bus(1, 32'h0000_0400));

    // reset while in S_WAIT; late data_ok ignored afterwards
    apply("rst_in_wait", mk(0, 0, 0, 0, 0, 0, 0, e_bus(0, 32'h0000_0400)));
    step("rst_late_dok1",  0, 0, 0, 1, 32'hcccc_cccc, 0, e_bus(0, 32'hbfc0_0000));
    step("rst_late_dok2",  0, 0, 0, 1, 32'hcccc_cccc, 0, e_bus(1, 32'hbfc0_0000));
    step("rst_refetch_hs", 0, 0, 1, 0, 0, 0,             e_bus(1, 32'hbfc0_0000));
    step("rst_refetch_d",  0, 0, 0, 1, 32'h2402_0001, 0, e_bus(0, 32'hbfc0_0000));
    step("rst_refetch_o",  0, 0, 0, 0, 0, 0,             e_hold(32'hbfc0_0000, 32'h2402_0001, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
